// File: rtl/iob_mem_responder_pkg.sv
// Shared IOb responder definitions: FSM state encoding, wait-counter width,
// out-of-range read pattern and the packed request width helper.
package iob_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int          CNT_W     = 4;
  localparam logic [31:0] OOR_RDATA = 32'hDEADBEEF;

  // {valid, address, wdata, wstrb}
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port byte-enabled synchronous RAM. Read data is registered and only
// updates on a read access (en_i with no strobes), so it holds between reads.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     din_i,
  output logic [DATA_W-1:0]     dout_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (|we_i) begin
        for (int i = 0; i < DATA_W / 8; i++)
          if (we_i[i]) mem[addr_i][i*8 +: 8] <= din_i[i*8 +: 8];
      end else begin
        dout_q <= mem[addr_i];
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native-bus responder: byte-strobed word memory answering after LATENCY
// cycles. IOB_MEM_RESPONDER_ERR_EN adds out-of-range detection and sticky err.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]   req,
  output logic [DATA_W:0]                    resp
`ifdef IOB_MEM_RESPONDER_ERR_EN
  ,
  output logic                               err
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  assign valid = req[REQ_W-1];
  assign addr  = req[REQ_W-2 -: ADDR_W];
  assign wdata = req[STRB_W +: DATA_W];
  assign wstrb = req[STRB_W-1:0];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, oor_q, oor, accept, ready;
  logic [DATA_W-1:0] ram_dout, rdata;
  logic              unused_addr;

  assign accept = (state_q == ST_IDLE) && valid;

`ifdef IOB_MEM_RESPONDER_ERR_EN
  assign oor = |addr[ADDR_W-1:MEM_ADDR_W+2];
`else
  assign oor = 1'b0;
`endif
  // Byte offset is implied by the strobes; upper bits alias when unchecked.
  assign unused_addr = ^{addr[1:0], addr[ADDR_W-1:MEM_ADDR_W+2]};

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk    (clk),
    .en_i   (accept && !oor),
    .we_i   (wstrb),
    .addr_i (addr[MEM_ADDR_W+1:2]),
    .din_i  (wdata),
    .dout_o (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (valid) begin
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q  <= ~|wstrb;
        oor_q <= oor;
      end
    end
  end

  assign ready = (state_q == ST_RESP);
  // Write responses and a discarded (reset) read present zero.
  assign rdata = !rd_q ? '0 : (oor_q ? DATA_W'(OOR_RDATA) : ram_dout);
  assign resp  = {rdata, ready};

`ifdef IOB_MEM_RESPONDER_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                err_q <= 1'b0;
    else if (ready && oor_q) err_q <= 1'b1;
  end
  assign err = err_q | (ready & oor_q);
`endif

endmodule

// File: tb/tb_iob_mem_responder.sv
// Directed bench for iob_mem_responder: one LATENCY=1 and one LATENCY=4 instance,
// expected read data queued at issue and compared at ready.
module tb_iob_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [68:0] req1, req4;
  logic [32:0] resp1, resp4;
`ifdef IOB_MEM_RESPONDER_ERR_EN
  logic        err1, err4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_rdy;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .req  (req1),
`ifdef IOB_MEM_RESPONDER_ERR_EN
    .err  (err1),
`endif
    .resp (resp1)
  );

  iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .req  (req4),
`ifdef IOB_MEM_RESPONDER_ERR_EN
    .err  (err4),
`endif
    .resp (resp4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge in IDLE; checks latency, rdata and the
  // single-cycle ready, then drops valid at the following negedge.
  task automatic txn(input string tag, input int which, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd);
    int   k   = 0;
    logic rdy = 1'b0;
    logic [32:0] r;
    int   lat = (which == 1) ? 1 : 4;
    exp_q.push_back(exp_rd);
    if (which == 1) req1 = {1'b1, a, d, s};
    else            req4 = {1'b1, a, d, s};
    r = '0;
    while (!rdy && k < 40) begin
      @(negedge clk);
      k++;
      r   = (which == 1) ? resp1 : resp4;
      rdy = r[0];
    end
    last_rdy = cyc;
    chk($sformatf("%s_lat", tag), 64'(k), 64'(lat));
    chk($sformatf("%s_rdata", tag), 64'(r[32:1]), 64'(exp_q.pop_front()));
    @(negedge clk);
    r = (which == 1) ? resp1 : resp4;
    chk($sformatf("%s_rdy_1cyc", tag), 64'(r[0]), 64'd0);
    if (which == 1) req1 = '0;
    else            req4 = '0;
  endtask

  initial begin
    int r0;
    rst  = 1'b0;
    req1 = '0;
    req4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp1", 64'(resp1), 64'd0);
    chk("rst_resp4", 64'(resp4), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_resp", 64'({resp1, resp4}), 64'd0);
    end

    // LATENCY=1 basics
    txn("wr10", 1, 32'h10, 32'hA5A5A5A5, 4'hF, 32'h0);
    txn("rd10", 1, 32'h10, 32'h0, 4'h0, 32'hA5A5A5A5);
    repeat (3) @(negedge clk);
    chk("rd_hold", 64'(resp1[32:1]), 64'hA5A5A5A5);
    txn("wr20", 1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0);
    txn("wr20p", 1, 32'h20, 32'h00001200, 4'h2, 32'h0);
    txn("rd20", 1, 32'h20, 32'h0, 4'h0, 32'hFFFF12FF);
    txn("wr24", 1, 32'h24, 32'h12345678, 4'hF, 32'h0);
    txn("rd24", 1, 32'h24, 32'h0, 4'h0, 32'h12345678);

    // LATENCY=4 back-to-back reads
    txn("wr0_l4", 4, 32'h0, 32'h11111111, 4'hF, 32'h0);
    txn("wr4_l4", 4, 32'h4, 32'h22222222, 4'hF, 32'h0);
    txn("rd0_l4", 4, 32'h0, 32'h0, 4'h0, 32'h11111111);
    r0 = last_rdy;
    txn("rd4_l4", 4, 32'h4, 32'h0, 4'h0, 32'h22222222);
    chk("b2b_gap", 64'(last_rdy - r0), 64'd5);

    // Reset while a LATENCY=4 write waits
    req4 = {1'b1, 32'h8, 32'hCAFEF00D, 4'hF};
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    req4 = '0;
    #1;
    chk("midrst_resp4", 64'(resp4), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_ready", 64'(resp4[0]), 64'd0);
    end
    txn("rd8_l4", 4, 32'h8, 32'h0, 4'h0, 32'hCAFEF00D);

`ifdef IOB_MEM_RESPONDER_ERR_EN
    chk("err_init", 64'(err1), 64'd0);
    txn("wr_oor", 1, 32'h1010, 32'h0, 4'hF, 32'h0);
    chk("err_set_wr", 64'(err1), 64'd1);
    txn("rd10_kept", 1, 32'h10, 32'h0, 4'h0, 32'hA5A5A5A5);
    txn("rd_oor", 1, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF);
    chk("err_sticky", 64'(err1), 64'd1);
    chk("err4_clear", 64'(err4), 64'd0);
`else
    txn("wr_alias", 1, 32'h1000, 32'h13572468, 4'hF, 32'h0);
    txn("rd_alias", 1, 32'h0, 32'h0, 4'h0, 32'h13572468);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_mem_responder.md
Name: iob_mem_responder

Overview:
- Responder (slave) end of the IOb native request/response bus. The CPU-side wrapper drives this bus as initiator on its instruction and data ports.
- Decodes a packed request, performs byte-strobed writes or word reads on an internal word memory, and returns a packed response after a programmable number of wait cycles.
- Sits behind the interconnect as a boot/scratch memory, or serves as a bus-functional target for core-level simulation.

Parameters:
- ADDR_W, 32, request address width (byte address).
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MEM_ADDR_W, 10, word-index width; memory depth is 2**MEM_ADDR_W words.
- LATENCY, 1, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous assert, active-low.
- req  in  REQ_W  packed request, MSB..LSB = {valid, address[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8.
- resp  out  RESP_W  packed response, MSB..LSB = {rdata[DATA_W-1:0], ready}; RESP_W = DATA_W+1.

Behaviour:
- Bus rules:
  - Initiator holds valid high with address, wdata and wstrb stable until it sees ready.
  - Initiator drops valid, or presents a new request, in the cycle after ready.
  - Operation type: wstrb != 0 is a write; wstrb == 0 is a read.
- Decode: word index = address[MEM_ADDR_W+1:2]. Address bits [1:0] are ignored; strobes already carry lane placement.
- FSM states IDLE, WAIT, RESP; reset state IDLE.
  - IDLE: valid=1 accepts the request at the edge.
    - Write: each byte lane i with wstrb[i]=1 is committed at that edge.
    - Read: the word is captured into the rdata register at that edge.
    - A wait counter is loaded with LATENCY-1.
    - Next state is RESP if LATENCY==1, else WAIT.
  - WAIT: counter decrements each cycle; at counter==1 the next state is RESP. valid is ignored.
  - RESP: ready=1 for exactly one cycle; next state is IDLE. valid in this cycle is ignored (old request still held).
- Latency and throughput:
  - ready rises exactly LATENCY cycles after the accepting edge.
  - Maximum rate is one transaction per LATENCY+1 cycles.
- rdata:
  - Read response: the captured word, held stable from capture until the next acceptance.
  - Write response: zero.
- Reset values: ready=0, rdata=0, FSM=IDLE, counter=0. Memory contents are not reset.
- Reset mid-operation: returns to IDLE with no ready pulse. A write already accepted stays committed. The pending read is discarded.
- Read-after-write to the same word in back-to-back transactions returns the newly written data.
- valid low in IDLE: no memory access, outputs hold.

Optional Feature:
- Macro: IOB_MEM_RESPONDER_ERR_EN.
- Defined:
  - An out-of-range request is one with address[ADDR_W-1:MEM_ADDR_W+2] != 0.
  - Out-of-range writes are dropped.
  - Out-of-range reads return 32'hDEADBEEF.
  - A 1-bit sticky output err sets with the ready of the offending transaction and clears only on reset.
- Undefined: upper address bits are ignored, so the address wraps modulo the memory depth. The err port is absent.

Decomposition:
- Shared header (existing intercon bus header), which holds:
  - REQ_W and RESP_W;
  - the valid/address/wdata/wstrb/rdata/ready field-slice macros;
  - an FSM state localparam set (2-bit encoding).
- Sub-module iob_ram_sp_be: single-port byte-enabled synchronous RAM with registered read; used for the memory array.

Test Plan:
- LATENCY=1; write addr 0x10, wdata 0xA5A5A5A5, wstrb 0xF, then read 0x10 -> ready 1 cycle after each acceptance; read rdata=0xA5A5A5A5; write-response rdata=0.
- Partial strobes: write 0x20 = 0xFFFFFFFF, then write 0x20 wdata 0x00001200 wstrb 0x2 -> read returns 0xFFFF12FF.
- LATENCY=4; back-to-back reads of 0x0 and 0x4 with valid held -> each ready exactly 4 cycles after its accept; second accept occurs the cycle after the first ready.
- Reset asserted during WAIT of a write (LATENCY=4) -> ready stays 0, FSM in IDLE; a subsequent read shows the write committed.
- valid held low for 50 cycles after reset -> ready=0 and rdata=0 throughout.
- With ERR_EN, MEM_ADDR_W=10; read 0x1000 -> rdata=0xDEADBEEF and err=1 sticky. Without ERR_EN, write 0x1000 then read 0x0 -> aliased data returned.
